// File: rtl/vec_issue_seq_if.sv
// Instruction push channel into the vector issue stage.
// Master drives words, slave (issue stage) returns ready.
interface vec_issue_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;

  modport master (
    output in_valid,
    output in_instr,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_instr,
    output in_ready
  );
endinterface

// File: rtl/vec_issue_seq.sv
// Vector issue stage: instruction FIFO, vlmul tracking, halt/resume
// and registered control bundle for the vector register file + ALU.
module vec_issue_seq #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  vec_issue_seq_if.slave   in_if,
  input  logic             resume,
  output logic [2:0]       vlmul,
  output logic [4:0]       op0_sel,
  output logic [4:0]       op1_sel,
  output logic [4:0]       wb_sel,
  output logic             wb_load,
  output logic [7:0]       alu_imm,
  output logic             alu_op1_sel,
  output logic [1:0]       alu_mode,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    S_RUN,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [31:0]      r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [2:0]       r_vlmul;
  logic [4:0]       r_op0;
  logic [4:0]       r_op1;
  logic [4:0]       r_wbs;
  logic             r_wb_load;
  logic [7:0]       r_imm;
  logic             r_isel;
  logic [1:0]       r_mode;
  logic             r_err;
  logic [CNT_W-1:0] r_retired;

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic [31:0] w_word;
  logic [1:0]  w_cls;
  logic [1:0]  w_mode;
  logic [4:0]  w_vd;
  logic [4:0]  w_vs0;
  logic [4:0]  w_vs1;
  logic [7:0]  w_imm;
  logic [2:0]  w_cfg;
  logic [4:0]  w_mask;
  logic        w_is_vv;
  logic        w_is_vi;
  logic        w_is_cfg;
  logic        w_is_halt;
  logic        w_alu_pop;
  logic        w_misal;
  logic        w_issue;
  logic        w_cfg_pop;
  logic        w_cfg_bad;
  logic        w_unused;

  // Extra pointer bit distinguishes full from empty.
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_push  = in_if.in_valid && !w_full;
  assign w_pop   = !w_empty && (r_state == S_RUN);

  assign w_word = r_mem[r_rptr[AW-1:0]];
  assign w_cls  = w_word[31:30];
  assign w_mode = w_word[29:28];
  assign w_vd   = w_word[27:23];
  assign w_vs0  = w_word[22:18];
  assign w_vs1  = w_word[17:13];
  assign w_imm  = w_word[12:5];
  assign w_cfg  = w_word[2:0];
  assign w_unused = ^w_word[4:3];

  always_comb begin
    w_is_vv   = 1'b0;
    w_is_vi   = 1'b0;
    w_is_cfg  = 1'b0;
    w_is_halt = 1'b0;
    unique case (1'b1)
      (w_cls == 2'b00): w_is_vv   = 1'b1;
      (w_cls == 2'b01): w_is_vi   = 1'b1;
      (w_cls == 2'b10): w_is_cfg  = 1'b1;
      (w_cls == 2'b11): w_is_halt = 1'b1;
      default: ;
    endcase
  end

  // vlmul never exceeds 3, so the group mask fits in 5 bits.
  assign w_mask  = (5'd1 << r_vlmul) - 5'd1;
  assign w_misal = (|(w_vd & w_mask)) ||
                   (|(w_vs0 & w_mask)) ||
                   (w_is_vv && |(w_vs1 & w_mask));

  assign w_alu_pop = w_pop && (w_is_vv || w_is_vi);
  assign w_issue   = w_alu_pop && !w_misal;
  assign w_cfg_pop = w_pop && w_is_cfg;
  assign w_cfg_bad = w_cfg_pop && w_cfg[2];

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_RUN:  if (w_pop && w_is_halt) w_state_nxt = S_HALT;
      S_HALT: if (resume)             w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= in_if.in_instr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_RUN;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_vlmul   <= '0;
      r_op0     <= '0;
      r_op1     <= '0;
      r_wbs     <= '0;
      r_wb_load <= 1'b0;
      r_imm     <= '0;
      r_isel    <= 1'b0;
      r_mode    <= '0;
      r_err     <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_wb_load <= w_issue;
      r_retired <= r_retired + CNT_W'(r_wb_load);
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if ((w_alu_pop && w_misal) || w_cfg_bad) r_err <= 1'b1;
      if (w_cfg_pop && !w_cfg[2]) r_vlmul <= w_cfg;
      if (w_issue) begin
        r_op0  <= w_vs0;
        r_wbs  <= w_vd;
        r_mode <= w_mode;
        r_isel <= w_is_vi;
        if (w_is_vv) r_op1 <= w_vs1;
        if (w_is_vi) r_imm <= w_imm;
      end
    end
  end

  assign in_if.in_ready = !w_full;
  assign vlmul       = r_vlmul;
  assign op0_sel     = r_op0;
  assign op1_sel     = r_op1;
  assign wb_sel      = r_wbs;
  assign wb_load     = r_wb_load;
  assign alu_imm     = r_imm;
  assign alu_op1_sel = r_isel;
  assign alu_mode    = r_mode;
  assign halted      = (r_state == S_HALT);
  assign err         = r_err;
  assign retired     = r_retired;

endmodule
